// File: rtl/i8008_bus_ctrl.sv
// i8008 bus-cycle controller: T-state tracking, address latch, memory req/ack handshake and PCC I/O.
// Optional macro MEM_CTRL_INTR_EN: controller owns INTR and jams an RST vvv opcode on the T1I cycle.
module i8008_bus_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int AWIDTH  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cpu_d_out,
  input  logic              cpu_sync,
  input  logic [2:0]        cpu_state,
  output logic [7:0]        cpu_d_in,
  output logic              cpu_ready,
  output logic              cpu_intr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              io_strobe,
  output logic [4:0]        io_port,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  input  logic              intr_req,
  input  logic [2:0]        intr_vec,
  output logic              bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] ST_T1  = 3'b010;
  localparam logic [2:0] ST_T1I = 3'b011;
  localparam logic [2:0] ST_T2  = 3'b001;
  localparam logic [2:0] ST_T3  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_REQ, S_WR_DATA, S_WR_REQ, S_DEC, S_IO, S_HOLD
  } state_t;

  state_t          state_q;
  logic [7:0]      addr_lo_q, t2_q;
  logic            pend_a_q, pend_t2_q, intr_cyc_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      cpu_d_in_q, mem_wdata_q, io_wdata_q;
  logic            cpu_ready_q, cpu_intr_q, mem_req_q, mem_we_q, io_strobe_q, bus_err_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [4:0]      io_port_q;

  logic sample_t1, sample_t1i, sample_t2, sample_t3, start_cycle;
  logic dec_go, t2_in_wr, timeout_hit;
  logic [7:0] dec_byte;

`ifdef MEM_CTRL_INTR_EN
  logic intr_req_q;
  assign sample_t1  = cpu_sync && (cpu_state == ST_T1);
  assign sample_t1i = cpu_sync && (cpu_state == ST_T1I);
`else
  logic intr_unused;
  assign intr_unused = ^{intr_req, intr_vec};
  assign sample_t1  = cpu_sync && ((cpu_state == ST_T1) || (cpu_state == ST_T1I));
  assign sample_t1i = 1'b0;
`endif

  assign sample_t2   = cpu_sync && (cpu_state == ST_T2);
  assign sample_t3   = cpu_sync && (cpu_state == ST_T3);
  assign start_cycle = sample_t1 || sample_t1i;
  assign t2_in_wr    = sample_t2 && pend_a_q;
  assign timeout_hit = mem_req_q && (cnt_q == CNT_LAST) && !mem_ack;

  // Decode runs either on a live T2 sample or one clk after a posted write drains with a T2 queued.
  assign dec_go   = ((state_q == S_ADDR) && sample_t2) || (state_q == S_DEC);
  assign dec_byte = (state_q == S_DEC) ? t2_q : cpu_d_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_lo_q   <= '0;
      t2_q        <= '0;
      pend_a_q    <= 1'b0;
      pend_t2_q   <= 1'b0;
      intr_cyc_q  <= 1'b0;
      cnt_q       <= '0;
      cpu_d_in_q  <= 8'h00;
      cpu_ready_q <= 1'b1;
      cpu_intr_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      io_strobe_q <= 1'b0;
      io_port_q   <= '0;
      io_wdata_q  <= '0;
      bus_err_q   <= 1'b0;
`ifdef MEM_CTRL_INTR_EN
      intr_req_q  <= 1'b0;
`endif
    end else begin
      io_strobe_q <= 1'b0;
      if (state_q == S_WR_REQ) begin
        // Posted write in flight: the core may already be addressing its next cycle.
        cnt_q <= cnt_q + 1'b1;
        if (start_cycle) begin
          addr_lo_q  <= cpu_d_out;
          pend_a_q   <= 1'b1;
          pend_t2_q  <= 1'b0;
          intr_cyc_q <= 1'b0;
        end else if (t2_in_wr) begin
          t2_q        <= cpu_d_out;
          pend_t2_q   <= 1'b1;
          cpu_ready_q <= 1'b0;
        end
        if (mem_ack || timeout_hit) begin
          mem_req_q <= 1'b0;
          if (!mem_ack) bus_err_q <= 1'b1;
          if (start_cycle) begin
            state_q     <= S_ADDR;
            cpu_ready_q <= 1'b1;
          end else if (pend_t2_q || t2_in_wr) begin
            state_q <= S_DEC;
          end else if (pend_a_q) begin
            state_q     <= S_ADDR;
            cpu_ready_q <= 1'b1;
          end else begin
            state_q     <= S_IDLE;
            cpu_ready_q <= 1'b1;
          end
        end
      end else if (start_cycle) begin
        state_q     <= S_ADDR;
        addr_lo_q   <= cpu_d_out;
        mem_req_q   <= 1'b0;
        cpu_ready_q <= 1'b1;
        intr_cyc_q  <= 1'b0;
      end else begin
        case (state_q)
          S_RD_REQ: begin
            cnt_q <= cnt_q + 1'b1;
            if (mem_ack) begin
              cpu_d_in_q  <= mem_rdata;
              cpu_ready_q <= 1'b1;
              mem_req_q   <= 1'b0;
              state_q     <= S_HOLD;
            end else if (timeout_hit) begin
              cpu_d_in_q  <= 8'hFF;
              cpu_ready_q <= 1'b1;
              mem_req_q   <= 1'b0;
              bus_err_q   <= 1'b1;
              state_q     <= S_HOLD;
            end
          end
          S_WR_DATA: begin
            if (sample_t3) begin
              mem_wdata_q <= cpu_d_out;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              cnt_q       <= '0;
              pend_a_q    <= 1'b0;
              pend_t2_q   <= 1'b0;
              state_q     <= S_WR_REQ;
            end
          end
          S_IO: begin
            if (io_port_q < 5'd8) cpu_d_in_q <= io_rdata;
            state_q <= S_HOLD;
          end
          S_HOLD: begin
            if (sample_t3) state_q <= S_IDLE;
          end
          default: ;
        endcase
        if (dec_go) begin
          if (intr_cyc_q) begin
            intr_cyc_q  <= 1'b0;
            cpu_ready_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            case (dec_byte[7:6])
              2'b11: begin
                mem_addr_q  <= AWIDTH'({dec_byte[5:0], addr_lo_q});
                cpu_ready_q <= 1'b1;
                state_q     <= S_WR_DATA;
              end
              2'b10: begin
                io_strobe_q <= 1'b1;
                io_port_q   <= dec_byte[5:1];
                io_wdata_q  <= addr_lo_q;
                cpu_ready_q <= 1'b1;
                state_q     <= S_IO;
              end
              default: begin
                mem_addr_q  <= AWIDTH'({dec_byte[5:0], addr_lo_q});
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                cnt_q       <= '0;
                cpu_ready_q <= 1'b0;
                state_q     <= S_RD_REQ;
              end
            endcase
          end
        end
      end
`ifdef MEM_CTRL_INTR_EN
      intr_req_q <= intr_req;
      if (sample_t1i) begin
        cpu_intr_q <= 1'b0;
        cpu_d_in_q <= {2'b00, intr_vec, 3'b101};
        intr_cyc_q <= 1'b1;
      end
      if (intr_req && !intr_req_q) cpu_intr_q <= 1'b1;
`endif
    end
  end

  assign cpu_d_in  = cpu_d_in_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_intr  = cpu_intr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign io_strobe = io_strobe_q;
  assign io_port   = io_port_q;
  assign io_wdata  = io_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_i8008_bus_ctrl.sv
// Directed bench for i8008_bus_ctrl: reset, PCR/PCI/PCW/PCC cycles, timeout and ack/timeout race.
module tb_i8008_bus_ctrl;

  localparam logic [2:0] T1 = 3'b010, T1I = 3'b011, T2 = 3'b001, WT = 3'b000, T3 = 3'b100, T4 = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cpu_d_out;
  logic        cpu_sync;
  logic [2:0]  cpu_state;
  logic [7:0]  cpu_d_in;
  logic        cpu_ready, cpu_intr, mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack, io_strobe;
  logic [4:0]  io_port;
  logic [7:0]  io_wdata, io_rdata;
  logic        intr_req;
  logic [2:0]  intr_vec;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  int lows;
  int n_req;

  always #5 clk = ~clk;

  i8008_bus_ctrl #(.TIMEOUT(16), .AWIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_d_out(cpu_d_out), .cpu_sync(cpu_sync), .cpu_state(cpu_state),
    .cpu_d_in(cpu_d_in), .cpu_ready(cpu_ready), .cpu_intr(cpu_intr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_strobe(io_strobe), .io_port(io_port), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .intr_req(intr_req), .intr_vec(intr_vec), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [2:0] st, input logic [7:0] d);
    cpu_sync  = 1'b1;
    cpu_state = st;
    cpu_d_out = d;
    tick();
    cpu_sync  = 1'b0;
    cpu_state = WT;
  endtask

  initial begin
    rst_n = 1'b0; cpu_d_out = 8'h00; cpu_sync = 1'b0; cpu_state = WT;
    mem_rdata = 8'h00; mem_ack = 1'b1; io_rdata = 8'h00; intr_req = 1'b0; intr_vec = 3'd0;

    // Reset with a stray ack present
    tick(); tick();
    check("rst_d_in", cpu_d_in, 8'h00);
    check("rst_ready", cpu_ready, 1);
    check("rst_intr", cpu_intr, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_strobe", io_strobe, 0);
    check("rst_port", io_port, 0);
    check("rst_iowdata", io_wdata, 0);
    check("rst_err", bus_err, 0);
    mem_ack = 1'b0; rst_n = 1'b1;
    tick();
    check("post_rst_req", mem_req, 0);

    // PCR read, ack on third wait clk
    sample(T1, 8'h34);
    check("pcr_t1_noreq", mem_req, 0);
    sample(T2, 8'h52);
    check("pcr_req", mem_req, 1);
    check("pcr_we", mem_we, 0);
    check("pcr_addr", mem_addr, 14'h1234);
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      if (!cpu_ready) lows++;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 8'hA5; end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("pcr_ready_low_clks", lows, 3);
    check("pcr_ready_back", cpu_ready, 1);
    check("pcr_d_in", cpu_d_in, 8'hA5);
    check("pcr_req_drop", mem_req, 0);
    tick();
    sample(T3, 8'h00);
    check("pcr_d_in_t3", cpu_d_in, 8'hA5);

    // PCW write, next cycle's T2 arrives before the write acks
    sample(T1, 8'hFF);
    sample(T2, 8'hFF);
    check("pcw_ready_t2", cpu_ready, 1);
    check("pcw_noreq_t2", mem_req, 0);
    sample(T3, 8'h5C);
    check("pcw_req", mem_req, 1);
    check("pcw_we", mem_we, 1);
    check("pcw_wdata", mem_wdata, 8'h5C);
    check("pcw_addr", mem_addr, 14'h3FFF);
    sample(T1, 8'h10);
    check("pcw_t1_ready", cpu_ready, 1);
    check("pcw_t1_addr_stable", mem_addr, 14'h3FFF);
    sample(T2, 8'h41);
    check("pcw_stall", cpu_ready, 0);
    tick();
    check("pcw_stall2", cpu_ready, 0);
    check("pcw_req_held", mem_req, 1);
    check("pcw_wdata_held", mem_wdata, 8'h5C);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("pcw_ack_drop", mem_req, 0);
    check("pcw_ack_ready", cpu_ready, 0);
    tick();
    check("pcw_next_req", mem_req, 1);
    check("pcw_next_we", mem_we, 0);
    check("pcw_next_addr", mem_addr, 14'h0110);
    mem_ack = 1'b1; mem_rdata = 8'h99; tick(); mem_ack = 1'b0;
    check("pcw_next_d_in", cpu_d_in, 8'h99);
    check("pcw_next_ready", cpu_ready, 1);
    check("pcw_no_err", bus_err, 0);
    sample(T3, 8'h00);

    // Stray T2 and T4 samples in IDLE
    sample(T2, 8'h00);
    check("idle_t2_ignored", mem_req, 0);
    sample(T4, 8'h00);
    check("idle_t4_ignored", mem_req, 0);

    // PCC input port 1
    io_rdata = 8'h3C;
    sample(T1, 8'h77);
    sample(T2, 8'h83);
    check("inp_strobe", io_strobe, 1);
    check("inp_port", io_port, 5'd1);
    check("inp_wdata", io_wdata, 8'h77);
    check("inp_noreq", mem_req, 0);
    tick();
    check("inp_strobe_1clk", io_strobe, 0);
    check("inp_d_in", cpu_d_in, 8'h3C);
    sample(T3, 8'h00);
    check("inp_d_in_t3", cpu_d_in, 8'h3C);

    // PCC output port 9
    io_rdata = 8'hEE;
    sample(T1, 8'h77);
    sample(T2, 8'h93);
    check("out_strobe", io_strobe, 1);
    check("out_port", io_port, 5'd9);
    check("out_wdata", io_wdata, 8'h77);
    check("out_ready", cpu_ready, 1);
    tick();
    check("out_strobe_1clk", io_strobe, 0);
    check("out_d_in_kept", cpu_d_in, 8'h3C);
    sample(T3, 8'h00);

    // PCI fetch with no ack
    sample(T1, 8'h00);
    sample(T2, 8'h00);
    n_req = 0;
    while (mem_req && n_req < 40) begin
      n_req++;
      tick();
    end
    check("to_req_clks", n_req, 16);
    check("to_err", bus_err, 1);
    check("to_d_in", cpu_d_in, 8'hFF);
    check("to_ready", cpu_ready, 1);
    sample(T3, 8'h00);

    // Reset in the middle of a read
    sample(T1, 8'h01);
    sample(T2, 8'h00);
    check("rmid_req", mem_req, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rmid_req_drop", mem_req, 0);
    tick();
    check("rmid_err_clear", bus_err, 0);
    check("rmid_ready", cpu_ready, 1);

    // Ack on the same clk the timeout would fire
    sample(T1, 8'h20);
    sample(T2, 8'h00);
    check("race_addr", mem_addr, 14'h0020);
    for (int i = 0; i < 15; i++) tick();
    check("race_req_high", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'h11; tick(); mem_ack = 1'b0;
    check("race_req_drop", mem_req, 0);
    check("race_no_err", bus_err, 0);
    check("race_d_in", cpu_d_in, 8'h11);
    check("race_ready", cpu_ready, 1);
    sample(T3, 8'h00);

`ifdef MEM_CTRL_INTR_EN
    // Interrupt acknowledge with RST 7
    intr_vec = 3'd7;
    intr_req = 1'b1; tick();
    check("irq_intr_set", cpu_intr, 1);
    tick(); tick();
    check("irq_intr_hold", cpu_intr, 1);
    sample(T1I, 8'h00);
    check("irq_intr_clr", cpu_intr, 0);
    check("irq_d_in", cpu_d_in, 8'h3D);
    sample(T2, 8'h00);
    check("irq_noreq", mem_req, 0);
    check("irq_ready", cpu_ready, 1);
    tick();
    check("irq_noreq2", mem_req, 0);
    sample(T3, 8'h00);
    check("irq_d_in_t3", cpu_d_in, 8'h3D);
    intr_req = 1'b0;
`else
    intr_req = 1'b1; tick();
    check("nointr_tied", cpu_intr, 0);
    intr_req = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
